// File: rtl/matbi_dma_job_scheduler_if.sv
// Job-producer and DMA-core signals of the matbi DMA job scheduler.
// The scheduler takes the master view; the producer/core environment takes the slave view.
interface matbi_dma_job_scheduler_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic             job_valid;
   logic             job_ready;
   logic [31:0]      job_rdma_ptr;
   logic [31:0]      job_rdma_len;
   logic [31:0]      job_wdma_ptr;
   logic [31:0]      job_wdma_len;
   logic [31:0]      job_value;
   logic             flush;
   logic [31:0]      rdma_mem_ptr;
   logic [31:0]      rdma_transfer_byte;
   logic [31:0]      wdma_mem_ptr;
   logic [31:0]      wdma_transfer_byte;
   logic [31:0]      value_to_add;
   logic             ap_start;
   logic             ap_ready;
   logic             ap_done;
   logic             ap_idle;
   logic             busy;
   logic             job_done;
   logic             skip_pulse;
   logic [CNT_W-1:0] jobs_done_cnt;
   logic [LVL_W-1:0] fifo_level;

   modport master (
      input  job_valid, job_rdma_ptr, job_rdma_len, job_wdma_ptr, job_wdma_len, job_value,
      input  flush, ap_ready, ap_done, ap_idle,
      output job_ready, rdma_mem_ptr, rdma_transfer_byte, wdma_mem_ptr, wdma_transfer_byte,
      output value_to_add, ap_start, busy, job_done, skip_pulse, jobs_done_cnt, fifo_level
   );

   modport slave (
      output job_valid, job_rdma_ptr, job_rdma_len, job_wdma_ptr, job_wdma_len, job_value,
      output flush, ap_ready, ap_done, ap_idle,
      input  job_ready, rdma_mem_ptr, rdma_transfer_byte, wdma_mem_ptr, wdma_transfer_byte,
      input  value_to_add, ap_start, busy, job_done, skip_pulse, jobs_done_cnt, fifo_level
   );
endinterface

// File: rtl/matbi_dma_job_scheduler.sv
// Job FIFO plus issue FSM: pops descriptors into the DMA core's config registers and runs
// the ap_start/ap_ready/ap_done handshake once per job, skipping zero-length jobs.
module matbi_dma_job_scheduler #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                        ACLK,
   input logic                        ARESET,
   matbi_dma_job_scheduler_if.master  bus
);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned LVL_W = AW + 1;

   typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [159:0]       mem_q [DEPTH];
   logic [159:0]       mem_d [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [31:0]        rptr_q, rptr_d;
   logic [31:0]        rlen_q, rlen_d;
   logic [31:0]        wptr_q, wptr_d;
   logic [31:0]        wlen_q, wlen_d;
   logic [31:0]        val_q, val_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               push;
   logic               pop;
   logic               full;

   assign full = (level_q == LVL_W'(DEPTH));
   assign push = bus.job_valid && !full && !bus.flush;
   assign pop  = (state_q == StIdle) && (level_q != '0) && bus.ap_idle && !bus.flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (bus.flush) begin
         // Discard queued entries by jumping the read pointer onto the write pointer.
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = {bus.job_rdma_ptr, bus.job_rdma_len, bus.job_wdma_ptr,
                               bus.job_wdma_len, bus.job_value};
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_comb begin
      rptr_d = rptr_q;
      rlen_d = rlen_q;
      wptr_d = wptr_q;
      wlen_d = wlen_q;
      val_d  = val_q;
      if (pop) begin
         {rptr_d, rlen_d, wptr_d, wlen_d, val_d} = mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (pop) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            if ((rlen_q == '0) && (wlen_q == '0)) begin
               state_d = StIdle;
            end else begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (bus.ap_ready) begin
               state_d = bus.ap_done ? StDone : StRun;
            end
         end
         StRun: begin
            if (bus.ap_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= StIdle;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rptr_q   <= '0;
         rlen_q   <= '0;
         wptr_q   <= '0;
         wlen_q   <= '0;
         val_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rptr_q   <= rptr_d;
         rlen_q   <= rlen_d;
         wptr_q   <= wptr_d;
         wlen_q   <= wlen_d;
         val_q    <= val_d;
         cnt_q    <= cnt_d;
      end
   end

   // All outputs decode registered state, so they drop as soon as reset asserts.
   assign bus.job_ready          = !full;
   assign bus.rdma_mem_ptr       = rptr_q;
   assign bus.rdma_transfer_byte = rlen_q;
   assign bus.wdma_mem_ptr       = wptr_q;
   assign bus.wdma_transfer_byte = wlen_q;
   assign bus.value_to_add       = val_q;
   assign bus.ap_start           = (state_q == StStart);
   assign bus.busy               = (state_q != StIdle);
   assign bus.job_done           = (state_q == StDone);
   assign bus.skip_pulse         = (state_q == StLoad) && (rlen_q == '0) && (wlen_q == '0);
   assign bus.jobs_done_cnt      = cnt_q;
   assign bus.fifo_level         = level_q;
endmodule

// File: tb/tb_matbi_dma_job_scheduler.sv
// Scoreboard bench: descriptors queued on push, compared against the config outputs
// when the scheduler starts (or skips) each job; a small core model answers the handshake.
module tb_matbi_dma_job_scheduler;
   typedef struct packed {
      logic [31:0] rp;
      logic [31:0] rl;
      logic [31:0] wp;
      logic [31:0] wl;
      logic [31:0] v;
   } job_t;

   logic ACLK;
   logic ARESET;

   matbi_dma_job_scheduler_if #(.DEPTH(4), .CNT_W(16)) bus ();

   matbi_dma_job_scheduler #(.DEPTH(4), .CNT_W(16)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int   n_vec = 0;
   int   n_err = 0;
   job_t exp_q[$];
   job_t mon_e;
   int   start_cnt = 0;
   int   start_hi = 0;
   int   skip_cnt = 0;
   int   done_seen = 0;
   int   exp_cnt = 0;
   bit   start_prev = 1'b0;

   int   rdy_delay = 0;
   int   done_delay = 10;
   bit   same_cyc = 1'b0;
   bit   core_act = 1'b0;
   int   core_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Core model: ready rdy_delay cycles after seeing ap_start, done done_delay cycles later.
   initial begin
      bus.ap_ready = 1'b0;
      bus.ap_done  = 1'b0;
      bus.ap_idle  = 1'b1;
      forever begin
         @(negedge ACLK);
         bus.ap_ready = 1'b0;
         bus.ap_done  = 1'b0;
         if (ARESET) begin
            core_act = 1'b0;
         end else begin
            if (!core_act && bus.ap_start) begin
               core_act = 1'b1;
               core_cnt = 0;
            end
            if (core_act) begin
               if (core_cnt == rdy_delay) begin
                  bus.ap_ready = 1'b1;
                  if (same_cyc) bus.ap_done = 1'b1;
               end
               if (!same_cyc && core_cnt == rdy_delay + done_delay) bus.ap_done = 1'b1;
               if ((same_cyc && core_cnt == rdy_delay) ||
                   (!same_cyc && core_cnt == rdy_delay + done_delay)) core_act = 1'b0;
               core_cnt++;
            end
         end
         bus.ap_idle = !core_act;
      end
   end

   initial begin
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            start_prev = 1'b0;
         end else begin
            if (bus.ap_start && !start_prev) begin
               start_cnt++;
               check("sb_nonempty_start", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("cfg_rdma_ptr", 64'(bus.rdma_mem_ptr), 64'(mon_e.rp));
                  check("cfg_rdma_len", 64'(bus.rdma_transfer_byte), 64'(mon_e.rl));
                  check("cfg_wdma_ptr", 64'(bus.wdma_mem_ptr), 64'(mon_e.wp));
                  check("cfg_wdma_len", 64'(bus.wdma_transfer_byte), 64'(mon_e.wl));
                  check("cfg_value", 64'(bus.value_to_add), 64'(mon_e.v));
               end
            end
            if (bus.ap_start) start_hi++;
            if (bus.skip_pulse) begin
               skip_cnt++;
               check("sb_nonempty_skip", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("skip_rdma_len", 64'(mon_e.rl), 64'd0);
                  check("skip_wdma_len", 64'(mon_e.wl), 64'd0);
                  check("skip_value", 64'(bus.value_to_add), 64'(mon_e.v));
               end
            end
            if (bus.job_done) done_seen++;
            start_prev = bus.ap_start;
         end
      end
   end

   task automatic push_job(input logic [31:0] rp, input logic [31:0] rl, input logic [31:0] wp,
                           input logic [31:0] wl, input logic [31:0] v);
      int   n;
      job_t j;
      n = 0;
      @(negedge ACLK);
      bus.job_rdma_ptr = rp;
      bus.job_rdma_len = rl;
      bus.job_wdma_ptr = wp;
      bus.job_wdma_len = wl;
      bus.job_value    = v;
      bus.job_valid    = 1'b1;
      while (!bus.job_ready && n < 500) begin
         @(negedge ACLK);
         n++;
      end
      check("push_timeout", 64'(n >= 500), 64'd0);
      j = '{rp: rp, rl: rl, wp: wp, wl: wl, v: v};
      exp_q.push_back(j);
      @(negedge ACLK);
      bus.job_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.busy || bus.fifo_level != 0) && n < 2000) begin
         @(negedge ACLK);
         n++;
      end
      check("idle_timeout", 64'(n >= 2000), 64'd0);
      repeat (2) @(negedge ACLK);
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (!bus.ap_start && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      while (bus.ap_start && n < 400) begin
         @(negedge ACLK);
         n++;
      end
      check("run_timeout", 64'(n >= 200), 64'd0);
   endtask

   int s0;
   int d0;

   initial begin
      ARESET           = 1'b1;
      bus.job_valid    = 1'b0;
      bus.job_rdma_ptr = '0;
      bus.job_rdma_len = '0;
      bus.job_wdma_ptr = '0;
      bus.job_wdma_len = '0;
      bus.job_value    = '0;
      bus.flush        = 1'b0;
      repeat (3) @(negedge ACLK);
      check("rst_ap_start", 64'(bus.ap_start), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_level", 64'(bus.fifo_level), 64'd0);
      check("rst_cnt", 64'(bus.jobs_done_cnt), 64'd0);
      check("rst_cfg", 64'(bus.rdma_mem_ptr | bus.value_to_add), 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_job_ready", 64'(bus.job_ready), 64'd1);

      // Single job, ready in the start cycle, done 10 cycles later.
      rdy_delay = 0; done_delay = 10; same_cyc = 1'b0; start_hi = 0; d0 = done_seen;
      push_job(32'h1000, 32'd64, 32'h2000, 32'd64, 32'd5);
      wait_idle();
      exp_cnt += 1;
      check("t1_start_hi", 64'(start_hi), 64'd1);
      check("t1_done_pulses", 64'(done_seen - d0), 64'd1);
      check("t1_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));
      check("t1_hold_rptr", 64'(bus.rdma_mem_ptr), 64'h1000);
      check("t1_hold_val", 64'(bus.value_to_add), 64'd5);

      // Back-to-back: fill the FIFO behind a long job, then a stalled fifth push.
      rdy_delay = 1; done_delay = 30;
      push_job(32'hA000, 32'd16, 32'hB000, 32'd16, 32'd1);
      for (int i = 0; i < 4; i++) begin
         push_job(32'hA100 + 32'(i), 32'd8 + 32'(i), 32'hB100 + 32'(i), 32'd4, 32'd10 + 32'(i));
      end
      check("t2_level_full", 64'(bus.fifo_level), 64'd4);
      check("t2_ready_full", 64'(bus.job_ready), 64'd0);
      d0 = done_seen;
      push_job(32'hA200, 32'd32, 32'hB200, 32'd32, 32'd99);
      check("t2_stall_until_pop", 64'(done_seen - d0), 64'd1);
      wait_idle();
      exp_cnt += 6;
      check("t2_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));

      // Zero-length job is skipped, the following one runs.
      rdy_delay = 0; done_delay = 4; s0 = start_cnt; skip_cnt = 0;
      push_job(32'hDEAD, 32'd0, 32'hBEEF, 32'd0, 32'd7);
      push_job(32'h3000, 32'd12, 32'h4000, 32'd0, 32'd8);
      wait_idle();
      exp_cnt += 1;
      check("t3_skips", 64'(skip_cnt), 64'd1);
      check("t3_starts", 64'(start_cnt - s0), 64'd1);
      check("t3_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));

      // ap_ready and ap_done together.
      rdy_delay = 1; same_cyc = 1'b1; d0 = done_seen;
      push_job(32'h5000, 32'd4, 32'h6000, 32'd4, 32'd3);
      push_job(32'h5100, 32'd4, 32'h6100, 32'd4, 32'd4);
      wait_idle();
      exp_cnt += 2;
      check("t4_done_pulses", 64'(done_seen - d0), 64'd2);
      check("t4_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));

      // Flush three queued jobs while one is in flight; a concurrent push is dropped.
      same_cyc = 1'b0; rdy_delay = 0; done_delay = 40;
      push_job(32'h7000, 32'd20, 32'h8000, 32'd20, 32'd11);
      push_job(32'h7100, 32'd20, 32'h8100, 32'd20, 32'd12);
      push_job(32'h7200, 32'd20, 32'h8200, 32'd20, 32'd13);
      push_job(32'h7300, 32'd20, 32'h8300, 32'd20, 32'd14);
      check("t5_level_pre", 64'(bus.fifo_level), 64'd3);
      @(negedge ACLK);
      bus.flush        = 1'b1;
      bus.job_valid    = 1'b1;
      bus.job_rdma_len = 32'd1;
      @(negedge ACLK);
      bus.flush     = 1'b0;
      bus.job_valid = 1'b0;
      check("t5_level_flushed", 64'(bus.fifo_level), 64'd0);
      check("t5_busy_inflight", 64'(bus.busy), 64'd1);
      exp_q.delete();
      s0 = start_cnt; d0 = done_seen;
      wait_idle();
      repeat (5) @(negedge ACLK);
      exp_cnt += 1;
      check("t5_no_start", 64'(start_cnt - s0), 64'd0);
      check("t5_inflight_done", 64'(done_seen - d0), 64'd1);
      check("t5_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));

      // Asynchronous reset while the core is running.
      done_delay = 50;
      push_job(32'h9000, 32'd8, 32'h9100, 32'd8, 32'd21);
      push_job(32'h9200, 32'd8, 32'h9300, 32'd8, 32'd22);
      wait_run();
      @(negedge ACLK);
      #2 ARESET = 1'b1;
      #1;
      check("t6_ap_start", 64'(bus.ap_start), 64'd0);
      check("t6_busy", 64'(bus.busy), 64'd0);
      check("t6_level", 64'(bus.fifo_level), 64'd0);
      check("t6_cnt", 64'(bus.jobs_done_cnt), 64'd0);
      exp_q.delete();
      exp_cnt = 0;
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      done_delay = 5;
      push_job(32'hC000, 32'd8, 32'hC100, 32'd8, 32'd30);
      wait_idle();
      exp_cnt += 1;
      check("t6_post_cnt", 64'(bus.jobs_done_cnt), 64'(exp_cnt));
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
